// File: rtl/m68k_bus_ctrl.sv
// 68000 bus-cycle controller: N address-decoded regions with per-region wait states, slave ready and BERR timeout.
// Latency: dtack_n low W+1 edges after the AS falling edge when rdy is high; a slave holding rdy low stretches the cycle until timeout.
module m68k_bus_ctrl #(
    parameter int C_REGIONS   = 4,
    parameter int C_ADDR_BITS = 23,
    parameter logic [C_REGIONS*C_ADDR_BITS-1:0] C_BASE = '0,
    parameter logic [C_REGIONS*C_ADDR_BITS-1:0] C_MASK = '0,
    parameter logic [C_REGIONS*4-1:0]           C_WAIT = '0,
    parameter int C_TIMEOUT   = 255
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      as_n,
    input  logic                      rw,
    input  logic                      uds_n,
    input  logic                      lds_n,
    input  logic [C_ADDR_BITS-1:0]    addr,
    input  logic [C_REGIONS-1:0]      rdy,
    input  logic [16*C_REGIONS-1:0]   slv_dout,
    output logic [C_REGIONS-1:0]      sel,
    output logic                      rd,
    output logic                      wr,
    output logic                      ub,
    output logic                      lb,
    output logic [15:0]               cpu_din,
    output logic                      dtack_n,
    output logic                      berr_n
);

    localparam int IW = (C_REGIONS > 1) ? $clog2(C_REGIONS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    logic [1:0]    state;
    logic          as_n_q;
    logic [IW-1:0] sel_idx;
    logic [3:0]    wcnt;
    logic [7:0]    tcnt;

    logic          hit;
    logic [IW-1:0] hit_idx;
    logic          start;
    logic          ack;
    logic          tmo;

    // Scan downward so the lowest matching region is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = C_REGIONS - 1; i >= 0; i--) begin
            if ((addr & C_MASK[i*C_ADDR_BITS +: C_ADDR_BITS]) == C_BASE[i*C_ADDR_BITS +: C_ADDR_BITS]) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

    assign start = ~as_n & as_n_q;
    assign ack   = (wcnt == 4'd0) && rdy[sel_idx];
    assign tmo   = (tcnt == 8'(C_TIMEOUT));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            as_n_q  <= 1'b1;
            sel     <= '0;
            sel_idx <= '0;
            rd      <= 1'b0;
            wr      <= 1'b0;
            ub      <= 1'b0;
            lb      <= 1'b0;
            cpu_din <= 16'h0000;
            dtack_n <= 1'b1;
            berr_n  <= 1'b1;
            wcnt    <= 4'd0;
            tcnt    <= 8'd0;
        end else begin
            as_n_q <= as_n;
            rd     <= 1'b0;
            wr     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (hit) begin
                            state   <= S_WAIT;
                            sel     <= C_REGIONS'(1) << hit_idx;
                            sel_idx <= hit_idx;
                            ub      <= ~uds_n;
                            lb      <= ~lds_n;
                            rd      <= rw;
                            wr      <= ~rw;
                            wcnt    <= C_WAIT[32'(hit_idx)*4 +: 4];
                            tcnt    <= 8'd0;
                        end else begin
                            state  <= S_ERR;
                            berr_n <= 1'b0;
                        end
                    end
                end
                S_WAIT: begin
                    // Strobe release beats ack, and ack beats a timeout on the same edge.
                    if (as_n) begin
                        state <= S_IDLE;
                        sel   <= '0;
                    end else if (ack) begin
                        state   <= S_ACK;
                        cpu_din <= slv_dout[32'(sel_idx)*16 +: 16];
                        dtack_n <= 1'b0;
                    end else if (tmo) begin
                        state  <= S_ERR;
                        berr_n <= 1'b0;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                        if (wcnt != 4'd0) begin
                            wcnt <= wcnt - 4'd1;
                        end
                    end
                end
                S_ACK: begin
                    if (as_n) begin
                        state   <= S_IDLE;
                        dtack_n <= 1'b1;
                        sel     <= '0;
                    end
                end
                S_ERR: begin
                    if (as_n) begin
                        state  <= S_IDLE;
                        berr_n <= 1'b1;
                        sel    <= '0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m68k_bus_ctrl.sv
// Bench for m68k_bus_ctrl: decode table, directed multi-cycle sequences, randomized cycles against a timing model.
module tb_m68k_bus_ctrl;

    localparam logic [91:0] P_BASE = {23'h020000, 23'h010000, 23'h000000, 23'h000000};
    localparam logic [91:0] P_MASK = {23'h7F0000, 23'h7F0000, 23'h078000, 23'h07C000};
    localparam logic [15:0] P_WAIT = {4'd0, 4'd3, 4'd1, 4'd0};
    localparam int          T_SHORT = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        as_n = 1'b1;
    logic        rw = 1'b1;
    logic        uds_n = 1'b1;
    logic        lds_n = 1'b1;
    logic [22:0] addr = '0;
    logic [3:0]  rdy = 4'hF;
    logic [63:0] slv_dout = '0;

    logic [3:0]  sel, sel_t;
    logic        rd, rd_t, wr, wr_t, ub, ub_t, lb, lb_t;
    logic [15:0] cpu_din, cpu_din_t;
    logic        dtack_n, dtack_n_t, berr_n, berr_n_t;

    m68k_bus_ctrl #(
        .C_REGIONS(4), .C_ADDR_BITS(23), .C_BASE(P_BASE), .C_MASK(P_MASK),
        .C_WAIT(P_WAIT), .C_TIMEOUT(255)
    ) dut (
        .clk(clk), .reset_n(reset_n), .as_n(as_n), .rw(rw), .uds_n(uds_n), .lds_n(lds_n),
        .addr(addr), .rdy(rdy), .slv_dout(slv_dout), .sel(sel), .rd(rd), .wr(wr),
        .ub(ub), .lb(lb), .cpu_din(cpu_din), .dtack_n(dtack_n), .berr_n(berr_n)
    );

    m68k_bus_ctrl #(
        .C_REGIONS(4), .C_ADDR_BITS(23), .C_BASE(P_BASE), .C_MASK(P_MASK),
        .C_WAIT(P_WAIT), .C_TIMEOUT(T_SHORT)
    ) dut_to (
        .clk(clk), .reset_n(reset_n), .as_n(as_n), .rw(rw), .uds_n(uds_n), .lds_n(lds_n),
        .addr(addr), .rdy(rdy), .slv_dout(slv_dout), .sel(sel_t), .rd(rd_t), .wr(wr_t),
        .ub(ub_t), .lb(lb_t), .cpu_din(cpu_din_t), .dtack_n(dtack_n_t), .berr_n(berr_n_t)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Region map as the bench understands it.
    logic [22:0] m_base[4] = '{23'h000000, 23'h000000, 23'h010000, 23'h020000};
    logic [22:0] m_mask[4] = '{23'h07C000, 23'h078000, 23'h7F0000, 23'h7F0000};
    int          m_wait[4] = '{0, 1, 3, 0};

    function automatic int ref_region(input logic [22:0] a);
        for (int i = 0; i < 4; i++) begin
            if ((a & m_mask[i]) == m_base[i]) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cycle(input logic [22:0] a, input logic r, input logic u, input logic l);
        addr  = a;
        rw    = r;
        uds_n = u;
        lds_n = l;
        as_n  = 1'b0;
        tick();
    endtask

    task automatic end_cycle();
        as_n = 1'b1;
        tick();
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, " sel"},     32'(sel), 32'h0);
        chk({nm, " rd"},      32'(rd), 32'h0);
        chk({nm, " wr"},      32'(wr), 32'h0);
        chk({nm, " ub"},      32'(ub), 32'h0);
        chk({nm, " lb"},      32'(lb), 32'h0);
        chk({nm, " cpu_din"}, 32'(cpu_din), 32'h0);
        chk({nm, " dtack_n"}, 32'(dtack_n), 32'h1);
        chk({nm, " berr_n"},  32'(berr_n), 32'h1);
    endtask

    typedef struct {
        logic [22:0] a;
        logic [3:0]  exp_sel;
    } dec_vec_t;

    dec_vec_t vt[8];

    int          r, w, rr, ack_e, last_e;
    logic        hit, ack_t, exp_dt, exp_dt_t, exp_be_t;
    logic [15:0] data, last_din, last_din_t;

    initial begin
        vt[0] = '{23'h000000, 4'b0001};
        vt[1] = '{23'h003FFF, 4'b0001};
        vt[2] = '{23'h400000, 4'b0001};
        vt[3] = '{23'h004000, 4'b0010};
        vt[4] = '{23'h010000, 4'b0100};
        vt[5] = '{23'h020ABC, 4'b1000};
        vt[6] = '{23'h008000, 4'b0000};
        vt[7] = '{23'h7FFFFF, 4'b0000};

        tick();
        tick();
        chk_reset_vals("reset");
        reset_n = 1'b1;
        tick();

        // Decode table; releasing the strobe on edge 1 also exercises the abort path.
        for (int i = 0; i < 8; i++) begin
            start_cycle(vt[i].a, 1'b1, 1'b0, 1'b0);
            chk($sformatf("dec%0d sel", i), 32'(sel), 32'(vt[i].exp_sel));
            chk($sformatf("dec%0d berr_n", i), 32'(berr_n), 32'(vt[i].exp_sel != 4'd0));
            chk($sformatf("dec%0d rd", i), 32'(rd), 32'(vt[i].exp_sel != 4'd0));
            end_cycle();
            chk($sformatf("dec%0d idle sel", i), 32'(sel), 32'h0);
            chk($sformatf("dec%0d idle dtack_n", i), 32'(dtack_n), 32'h1);
            chk($sformatf("dec%0d idle berr_n", i), 32'(berr_n), 32'h1);
        end

        // Zero-wait read from region 0.
        slv_dout = {16'h3333, 16'h2222, 16'h1111, 16'h4E71};
        start_cycle(23'h000100, 1'b1, 1'b0, 1'b0);
        chk("rd0 rd", 32'(rd), 32'h1);
        chk("rd0 wr", 32'(wr), 32'h0);
        chk("rd0 dtack e0", 32'(dtack_n), 32'h1);
        chk("rd0 ublb", 32'({ub, lb}), 32'h3);
        tick();
        chk("rd0 rd e1", 32'(rd), 32'h0);
        chk("rd0 dtack e1", 32'(dtack_n), 32'h0);
        chk("rd0 din", 32'(cpu_din), 32'h4E71);
        slv_dout[15:0] = 16'hFFFF;
        tick();
        chk("rd0 din hold", 32'(cpu_din), 32'h4E71);
        chk("rd0 dtack hold", 32'(dtack_n), 32'h0);
        end_cycle();
        chk("rd0 dtack rel", 32'(dtack_n), 32'h1);
        chk("rd0 sel rel", 32'(sel), 32'h0);

        // Upper-byte write to region 2 with three wait states.
        start_cycle(23'h010004, 1'b0, 1'b0, 1'b1);
        chk("wr2 wr", 32'(wr), 32'h1);
        chk("wr2 rd", 32'(rd), 32'h0);
        chk("wr2 sel", 32'(sel), 32'h4);
        chk("wr2 ublb", 32'({ub, lb}), 32'h2);
        for (int e = 1; e <= 3; e++) begin
            tick();
            chk($sformatf("wr2 wr e%0d", e), 32'(wr), 32'h0);
            chk($sformatf("wr2 dtack e%0d", e), 32'(dtack_n), 32'h1);
        end
        tick();
        chk("wr2 dtack e4", 32'(dtack_n), 32'h0);
        end_cycle();

        // Region 3 slave holds rdy low for ten edges.
        rdy = 4'b0111;
        start_cycle(23'h020000, 1'b1, 1'b0, 1'b0);
        for (int e = 1; e <= 10; e++) begin
            tick();
            chk($sformatf("rdy3 dtack e%0d", e), 32'(dtack_n), 32'h1);
        end
        rdy = 4'hF;
        tick();
        chk("rdy3 dtack e11", 32'(dtack_n), 32'h0);
        chk("rdy3 berr_n", 32'(berr_n), 32'h1);
        chk("rdy3 din", 32'(cpu_din), 32'h3333);
        end_cycle();

        // Unmapped address.
        start_cycle(23'h7FFFFF, 1'b1, 1'b0, 1'b0);
        chk("miss rdwr", 32'({rd, wr}), 32'h0);
        chk("miss berr e0", 32'(berr_n), 32'h0);
        tick();
        tick();
        chk("miss berr held", 32'(berr_n), 32'h0);
        chk("miss dtack", 32'(dtack_n), 32'h1);
        end_cycle();
        chk("miss berr rel", 32'(berr_n), 32'h1);

        // Timeout on the short-timeout instance, then ack on the timeout edge.
        rdy = 4'b0111;
        start_cycle(23'h020000, 1'b1, 1'b0, 1'b0);
        for (int e = 1; e <= 8; e++) tick();
        chk("tmo berr e8", 32'(berr_n_t), 32'h1);
        tick();
        chk("tmo berr e9", 32'(berr_n_t), 32'h0);
        chk("tmo dtack e9", 32'(dtack_n_t), 32'h1);
        end_cycle();
        chk("tmo berr rel", 32'(berr_n_t), 32'h1);
        start_cycle(23'h020000, 1'b1, 1'b0, 1'b0);
        for (int e = 1; e <= 8; e++) tick();
        rdy = 4'hF;
        tick();
        chk("tmo tie dtack", 32'(dtack_n_t), 32'h0);
        chk("tmo tie berr", 32'(berr_n_t), 32'h1);
        end_cycle();

        // Strobe released mid-WAIT.
        start_cycle(23'h010000, 1'b1, 1'b0, 1'b0);
        tick();
        as_n = 1'b1;
        tick();
        chk("abort sel", 32'(sel), 32'h0);
        chk("abort dtack", 32'(dtack_n), 32'h1);
        tick();
        chk("abort dtack later", 32'(dtack_n), 32'h1);

        // Reset while in ACK, then reset coinciding with a start edge.
        slv_dout[15:0] = 16'h4E71;
        start_cycle(23'h000000, 1'b1, 1'b0, 1'b0);
        tick();
        chk("rst ack dtack", 32'(dtack_n), 32'h0);
        reset_n = 1'b0;
        tick();
        chk_reset_vals("rst ack");
        as_n = 1'b1;
        tick();
        reset_n = 1'b1;
        tick();
        reset_n = 1'b0;
        start_cycle(23'h000000, 1'b1, 1'b0, 1'b0);
        chk("rst drop rd", 32'(rd), 32'h0);
        chk("rst drop sel", 32'(sel), 32'h0);
        as_n = 1'b1;
        tick();
        reset_n = 1'b1;
        tick();

        // Randomized cycles against the timing model; both instances start from reset.
        last_din   = 16'h0;
        last_din_t = 16'h0;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0: addr = 23'($urandom) & 23'h783FFF;
                1: addr = (23'($urandom) & 23'h783FFF) | 23'h004000;
                2: addr = 23'h010000 | (23'($urandom) & 23'h00FFFF);
                3: addr = 23'h020000 | (23'($urandom) & 23'h00FFFF);
                default: addr = 23'h7F0000 | (23'($urandom) & 23'h00FFFF);
            endcase
            r        = ref_region(addr);
            hit      = (r >= 0);
            w        = hit ? m_wait[r] : 0;
            rr       = $urandom_range(0, 15);
            ack_e    = (rr > w + 1) ? rr : w + 1;
            ack_t    = hit && (ack_e <= T_SHORT + 1);
            slv_dout = {$urandom, $urandom};
            data     = hit ? slv_dout[r*16 +: 16] : 16'h0;
            rdy      = 4'($urandom);
            start_cycle(addr, 1'($urandom), 1'($urandom), 1'($urandom));
            chk($sformatf("rnd%0d sel", n), 32'(sel), hit ? (32'h1 << r) : 32'h0);
            chk($sformatf("rnd%0d rd", n), 32'(rd), 32'(hit && rw));
            chk($sformatf("rnd%0d wr", n), 32'(wr), 32'(hit && !rw));
            chk($sformatf("rnd%0d berr e0", n), 32'(berr_n), 32'(hit));
            if (hit) chk($sformatf("rnd%0d ublb", n), 32'({ub, lb}), 32'({~uds_n, ~lds_n}));
            last_e = hit ? ack_e + 1 : 3;
            for (int e = 1; e <= last_e; e++) begin
                rdy = 4'($urandom);
                if (hit) rdy[r] = (e >= rr);
                tick();
                exp_dt   = hit && (e >= ack_e);
                exp_dt_t = ack_t && (e >= ack_e);
                exp_be_t = hit && (ack_t || e < T_SHORT + 1);
                if (exp_dt && e == ack_e) last_din = data;
                if (exp_dt_t && e == ack_e) last_din_t = data;
                chk($sformatf("rnd%0d dtack e%0d", n, e), 32'(dtack_n), 32'(!exp_dt));
                chk($sformatf("rnd%0d berr e%0d", n, e), 32'(berr_n), 32'(hit));
                chk($sformatf("rnd%0d din e%0d", n, e), 32'(cpu_din), 32'(last_din));
                chk($sformatf("rnd%0d t dtack e%0d", n, e), 32'(dtack_n_t), 32'(!exp_dt_t));
                chk($sformatf("rnd%0d t berr e%0d", n, e), 32'(berr_n_t), 32'(exp_be_t));
                chk($sformatf("rnd%0d t din e%0d", n, e), 32'(cpu_din_t), 32'(last_din_t));
            end
            end_cycle();
            chk($sformatf("rnd%0d end", n), 32'({sel, dtack_n, berr_n, dtack_n_t, berr_n_t}), 32'h0F);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
